clk_sw_ctrl: RTL and testbench

CLK_SW_CTRL -- requirements
Module: clk_sw_ctrl

---
 rtl/clk_sw_pkg.sv | 15 +
 rtl/clk_sw_ctrl_if.sv | 22 ++
 rtl/bit_sync.sv | 25 ++
 rtl/clk_sw_ctrl.sv | 145 ++++++++++++++
 tb/tb_clk_sw_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/clk_sw_pkg.sv
// Shared types and defaults for the glitch-free clock switch controller.
package clk_sw_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_BREAK,
    ST_MAKE,
    ST_ERR
  } sw_state_e;

  localparam int TIMEOUT_CYC_DEF = 64;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/clk_sw_ctrl_if.sv
// Request/status bundle between the switch controller and its requester / clock mux.
interface clk_sw_ctrl_if;
  logic sw_req;
  logic sw_target;
  logic stat0;
  logic stat1;
  logic select;
  logic cur_sel;
  logic busy;
  logic done;
  logic err;

  modport master (
    output sw_req, sw_target, stat0, stat1,
    input  select, cur_sel, busy, done, err
  );

  modport slave (
    input  sw_req, sw_target, stat0, stat1,
    output select, cur_sel, busy, done, err
  );
endinterface

// File: rtl/bit_sync.sv
// Multi-flop single-bit synchronizer with asynchronous active-low reset.
module bit_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_d;
  logic [DEPTH-1:0] sync_q;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/clk_sw_ctrl.sv
// Break-before-make sequencer driving the select of a glitch-free clock mux,
// with a per-sequence timeout and detection of both branches enabled at once.
module clk_sw_ctrl
  import clk_sw_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic         clk,
  input logic         rst_n,
  clk_sw_ctrl_if.slave sw
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYC);

  logic stat0_s, stat1_s;

  bit_sync #(.DEPTH(SYNC_STAGES)) u_sync0 (
    .clk(clk), .rst_n(rst_n), .d_i(sw.stat0), .q_o(stat0_s)
  );
  bit_sync #(.DEPTH(SYNC_STAGES)) u_sync1 (
    .clk(clk), .rst_n(rst_n), .d_i(sw.stat1), .q_o(stat1_s)
  );

  sw_state_e     state_d, state_q;
  logic          select_d, select_q;
  logic          cur_sel_d, cur_sel_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;
  logic          err_d, err_q;
  logic [TW-1:0] timer_d, timer_q;

  logic          accept, both_hi, old_stat, tgt_stat, timed_out;
  logic [TW-1:0] timer_inc;

  always_comb begin
    accept    = sw.sw_req && ((state_q == ST_IDLE) || (state_q == ST_ERR));
    both_hi   = stat0_s && stat1_s;
    // select=1 routes clk0, so each source's status is the opposite-numbered stat
    old_stat  = cur_sel_q ? stat0_s : stat1_s;
    tgt_stat  = select_q ? stat0_s : stat1_s;
    timer_inc = (timer_q == TMO) ? TMO : timer_q + TW'(1);
    timed_out = (timer_inc == TMO);

    state_d   = state_q;
    select_d  = select_q;
    cur_sel_d = cur_sel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    timer_d   = timer_q;

    if (both_hi) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          timer_d = timer_inc;
          if (stat1_s) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else if (timed_out) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
        ST_IDLE, ST_ERR: begin
          if (accept) begin
            if ((state_q == ST_IDLE) && (sw.sw_target == cur_sel_q)) begin
              done_d = 1'b1;
            end else begin
              state_d  = ST_BREAK;
              select_d = sw.sw_target;
              busy_d   = 1'b1;
              err_d    = 1'b0;
              timer_d  = '0;
            end
          end
        end
        ST_BREAK: begin
          timer_d = timer_inc;
          if (timed_out) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else if (!old_stat) begin
            state_d = ST_MAKE;
          end
        end
        ST_MAKE: begin
          // completion wins over a timeout landing on the same cycle
          if (tgt_stat) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            cur_sel_d = select_q;
            busy_d    = 1'b0;
          end else begin
            timer_d = timer_inc;
            if (timed_out) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
        default: begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      select_q  <= 1'b0;
      cur_sel_q <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      select_q  <= select_d;
      cur_sel_q <= cur_sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
    end
  end

  assign sw.select  = select_q;
  assign sw.cur_sel = cur_sel_q;
  assign sw.busy    = busy_q;
  assign sw.done    = done_q;
  assign sw.err     = err_q;

endmodule

// File: tb/tb_clk_sw_ctrl.sv
// Directed bench for clk_sw_ctrl: init, same-source request, full switch,
// timeout and recovery, both-enabled fault, ignored requests and mid-sequence reset.
module tb_clk_sw_ctrl;

  localparam int TMO = 16;
  localparam int SS  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clk_sw_ctrl_if sw_if ();

  clk_sw_ctrl #(.TIMEOUT_CYC(TMO), .SYNC_STAGES(SS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw_if)
  );

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int excl_cnt = 0;
  int dc0;

  always @(posedge clk) begin
    if (sw_if.done) done_cnt <= done_cnt + 1;
    if (sw_if.done && sw_if.err) excl_cnt <= excl_cnt + 1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_req(input logic tgt);
    sw_if.sw_req    = 1'b1;
    sw_if.sw_target = tgt;
    tick(1);
    sw_if.sw_req    = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_eq({tag, "_select"},  sw_if.select,  0);
    chk_eq({tag, "_cur_sel"}, sw_if.cur_sel, 0);
    chk_eq({tag, "_busy"},    sw_if.busy,    1);
    chk_eq({tag, "_done"},    sw_if.done,    0);
    chk_eq({tag, "_err"},     sw_if.err,     0);
  endtask

  task automatic do_reset_init();
    rst_n           = 1'b0;
    sw_if.sw_req    = 1'b0;
    sw_if.sw_target = 1'b0;
    sw_if.stat0     = 1'b0;
    sw_if.stat1     = 1'b0;
    tick(2);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick(2);
    chk_eq("init_wait_busy", sw_if.busy, 1);
    sw_if.stat1 = 1'b1;
    tick(SS);
    chk_eq("init_sync_busy", sw_if.busy, 1);
    tick(1);
    chk_eq("init_done_busy", sw_if.busy, 0);
    chk_eq("init_cur_sel", sw_if.cur_sel, 0);
    chk_eq("init_select", sw_if.select, 0);
    chk_eq("init_err", sw_if.err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and init
    do_reset_init();

    // Request for the already-active source
    dc0 = done_cnt;
    pulse_req(1'b0);
    chk_eq("same_done", sw_if.done, 1);
    chk_eq("same_busy", sw_if.busy, 0);
    chk_eq("same_select", sw_if.select, 0);
    tick(1);
    chk_eq("same_done_clr", sw_if.done, 0);
    chk_eq("same_done_cnt", done_cnt - dc0, 1);

    // Full switch to clk0 branch
    dc0 = done_cnt;
    pulse_req(1'b1);
    chk_eq("sw_select", sw_if.select, 1);
    chk_eq("sw_busy", sw_if.busy, 1);
    chk_eq("sw_cur_sel_hold", sw_if.cur_sel, 0);
    tick(3);
    sw_if.stat1 = 1'b0;
    tick(4);
    sw_if.stat0 = 1'b1;
    tick(2);
    chk_eq("sw_done_early", sw_if.done, 0);
    tick(1);
    chk_eq("sw_done", sw_if.done, 1);
    chk_eq("sw_cur_sel", sw_if.cur_sel, 1);
    chk_eq("sw_busy_clr", sw_if.busy, 0);
    chk_eq("sw_err", sw_if.err, 0);
    tick(1);
    chk_eq("sw_done_cnt", done_cnt - dc0, 1);

    // Timeout with old source never dropping, then recovery
    do_reset_init();
    pulse_req(1'b1);
    tick(15);
    chk_eq("tmo_err_early", sw_if.err, 0);
    chk_eq("tmo_busy_early", sw_if.busy, 1);
    tick(1);
    chk_eq("tmo_err", sw_if.err, 1);
    chk_eq("tmo_busy", sw_if.busy, 0);
    chk_eq("tmo_cur_sel", sw_if.cur_sel, 0);
    chk_eq("tmo_select", sw_if.select, 1);
    tick(3);
    chk_eq("tmo_err_sticky", sw_if.err, 1);
    pulse_req(1'b1);
    chk_eq("rec_err_clr", sw_if.err, 0);
    chk_eq("rec_busy", sw_if.busy, 1);
    sw_if.stat1 = 1'b0;
    tick(4);
    sw_if.stat0 = 1'b1;
    tick(2);
    chk_eq("rec_done_early", sw_if.done, 0);
    tick(1);
    chk_eq("rec_done", sw_if.done, 1);
    chk_eq("rec_cur_sel", sw_if.cur_sel, 1);
    chk_eq("rec_err", sw_if.err, 0);

    // Both branches enabled during MAKE
    do_reset_init();
    dc0 = done_cnt;
    pulse_req(1'b1);
    sw_if.stat1 = 1'b0;
    tick(3);
    sw_if.stat0 = 1'b1;
    sw_if.stat1 = 1'b1;
    tick(SS);
    chk_eq("both_err_early", sw_if.err, 0);
    tick(1);
    chk_eq("both_err", sw_if.err, 1);
    chk_eq("both_done", sw_if.done, 0);
    chk_eq("both_busy", sw_if.busy, 0);
    chk_eq("both_cur_sel", sw_if.cur_sel, 0);
    tick(2);
    chk_eq("both_done_cnt", done_cnt - dc0, 0);

    // Ignored requests during BREAK/MAKE, then reset mid-MAKE
    do_reset_init();
    dc0 = done_cnt;
    pulse_req(1'b1);
    tick(1);
    pulse_req(1'b0);
    chk_eq("ign_brk_select", sw_if.select, 1);
    chk_eq("ign_brk_busy", sw_if.busy, 1);
    chk_eq("ign_brk_done", sw_if.done, 0);
    sw_if.stat1 = 1'b0;
    tick(3);
    pulse_req(1'b0);
    chk_eq("ign_mk_select", sw_if.select, 1);
    chk_eq("ign_mk_busy", sw_if.busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    tick(2);
    chk_eq("abort_done_cnt", done_cnt - dc0, 0);
    chk_eq("abort_err", sw_if.err, 0);

    chk_eq("done_err_excl", excl_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
